// File: rtl/rmii_tx.sv
`default_nettype none
// ============================================================================
// Module  : rmii_tx
// Brief   : 100 Mb/s RMII transmit MAC: preamble/SFD, body, pad, CRC-32, IFG.
// Revision: 1.0  initial release
// ============================================================================
module rmii_tx #(
   parameter int MIN_LEN    = 60,
   parameter bit PAD_EN     = 1'b1,
   parameter int IFG_CYCLES = 48
) (
   input  logic        REF_CLK,
   input  logic        arst,
   output logic        TXD0,
   output logic        TXD1,
   output logic        TX_EN,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_dout,
   input  logic        fifo_EOD_out,
   output logic        fifo_rden,
   output logic [15:0] succ_tx_count_gray,
   output logic [15:0] underrun_count_gray
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRE   = 3'd1,
      S_BODY  = 3'd2,
      S_PAD   = 3'd3,
      S_FCS   = 3'd4,
      S_ABORT = 3'd5,
      S_IFG   = 3'd6
   } state_t;

   localparam logic [31:0] c_POLY     = 32'hEDB88320;
   localparam logic [15:0] c_IFG_LAST = 16'(IFG_CYCLES - 1);
   localparam logic [10:0] c_BYTE_MAX = 11'h7FF;

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_dib;
   logic [15:0] r_cnt;
   logic [7:0]  r_shift, r_hold;
   logic        r_shift_eod, r_hold_eod, r_pend;
   logic [31:0] r_crc, w_crc_nxt;
   logic [10:0] r_bytes, w_bytes_nxt;
   logic [15:0] r_succ_cnt, r_urun_cnt, r_succ_gray, r_urun_gray;
   logic [1:0]  r_txd, w_dibit;
   logic        r_tx_en, w_tx_en, w_rden, w_start, w_abort, w_succ_inc, w_short;

   function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
      crc_step = (c >> 1) ^ ((c[0] ^ b) ? c_POLY : 32'h0);
   endfunction

   assign w_bytes_nxt = (r_bytes == c_BYTE_MAX) ? r_bytes : r_bytes + 11'd1;
   assign w_short     = int'(w_bytes_nxt) < MIN_LEN;
   assign w_crc_nxt   = crc_step(crc_step(r_crc, w_dibit[0]), w_dibit[1]);

   // The IDLE cycle that launches a frame already emits the first preamble dibit.
   always_comb begin
      w_state_nxt = r_state;
      w_rden      = 1'b0;
      w_dibit     = 2'b00;
      w_tx_en     = 1'b0;
      w_start     = 1'b0;
      w_abort     = 1'b0;
      w_succ_inc  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!fifo_empty) begin
               w_start     = 1'b1;
               w_rden      = 1'b1;
               w_tx_en     = 1'b1;
               w_dibit     = 2'b01;
               w_state_nxt = S_PRE;
            end
         end
         S_PRE: begin
            w_tx_en = 1'b1;
            w_dibit = (r_cnt == 16'd31) ? 2'b11 : 2'b01;
            if (r_cnt == 16'd31) w_state_nxt = S_BODY;
         end
         S_BODY: begin
            w_tx_en = 1'b1;
            w_dibit = r_shift[1:0];
            if (r_dib == 2'd0 && !r_shift_eod) begin
               if (fifo_empty) begin
                  w_abort     = 1'b1;
                  w_tx_en     = 1'b0;
                  w_state_nxt = S_ABORT;
               end else begin
                  w_rden = 1'b1;
               end
            end
            if (r_dib == 2'd3 && r_shift_eod)
               w_state_nxt = (PAD_EN && w_short) ? S_PAD : S_FCS;
         end
         S_PAD: begin
            w_tx_en = 1'b1;
            if (r_dib == 2'd3 && !w_short) w_state_nxt = S_FCS;
         end
         S_FCS: begin
            w_tx_en = 1'b1;
            w_dibit = ~r_crc[1:0];
            if (r_cnt == 16'd15) begin
               w_succ_inc  = 1'b1;
               w_state_nxt = S_IFG;
            end
         end
         S_ABORT: begin
            // One pop in flight at a time so nothing past the EOD byte is consumed.
            w_rden = !fifo_empty && !r_pend;
            if (r_pend && fifo_EOD_out) w_state_nxt = S_IFG;
         end
         S_IFG: begin
            if (r_cnt >= c_IFG_LAST) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IFG;
      endcase
   end

   always_ff @(posedge REF_CLK or posedge arst) begin
      if (arst) begin
         r_state     <= S_IDLE;
         r_dib       <= 2'd0;
         r_cnt       <= 16'd0;
         r_shift     <= 8'h00;
         r_shift_eod <= 1'b0;
         r_hold      <= 8'h00;
         r_hold_eod  <= 1'b0;
         r_pend      <= 1'b0;
         r_crc       <= 32'hFFFF_FFFF;
         r_bytes     <= 11'd0;
         r_succ_cnt  <= 16'd0;
         r_urun_cnt  <= 16'd0;
         r_succ_gray <= 16'd0;
         r_urun_gray <= 16'd0;
         r_txd       <= 2'b00;
         r_tx_en     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_pend  <= w_rden;
         r_tx_en <= w_tx_en;
         r_txd   <= w_tx_en ? w_dibit : 2'b00;
         r_dib   <= w_tx_en ? r_dib + 2'd1 : 2'd0;
         r_cnt   <= (w_state_nxt != r_state) ? (w_start ? 16'd1 : 16'd0) : r_cnt + 16'd1;

         if (r_pend) begin
            r_hold     <= fifo_dout;
            r_hold_eod <= fifo_EOD_out;
         end

         if (r_state == S_PRE && r_cnt == 16'd31) begin
            r_shift     <= r_hold;
            r_shift_eod <= r_hold_eod;
         end else if (r_state == S_BODY && r_dib == 2'd3) begin
            r_shift     <= r_shift_eod ? 8'h00 : r_hold;
            r_shift_eod <= r_shift_eod | r_hold_eod;
         end else begin
            r_shift <= r_shift >> 2;
         end

         if (r_state == S_IDLE || r_state == S_PRE)
            r_crc <= 32'hFFFF_FFFF;
         else if (r_state == S_BODY || r_state == S_PAD)
            r_crc <= w_crc_nxt;
         else if (r_state == S_FCS)
            r_crc <= r_crc >> 2;

         if (r_state == S_IDLE)
            r_bytes <= 11'd0;
         else if ((r_state == S_BODY || r_state == S_PAD) && r_dib == 2'd3)
            r_bytes <= w_bytes_nxt;

         r_succ_cnt  <= r_succ_cnt + {15'd0, w_succ_inc};
         r_urun_cnt  <= r_urun_cnt + {15'd0, w_abort};
         r_succ_gray <= r_succ_cnt ^ (r_succ_cnt >> 1);
         r_urun_gray <= r_urun_cnt ^ (r_urun_cnt >> 1);
      end
   end

   assign TXD0                = r_txd[0];
   assign TXD1                = r_txd[1];
   assign TX_EN               = r_tx_en;
   assign fifo_rden           = w_rden;
   assign succ_tx_count_gray  = r_succ_gray;
   assign underrun_count_gray = r_urun_gray;

endmodule
`default_nettype wire
